// File: rtl/mem_access_ctrl.sv
// =============================================================================
// mem_access_ctrl : LC-3b MEM-stage sequencer (direct and LDI/STI accesses)
// Optional watchdog: define MEM_TIMEOUT_EN.      Revision 1.0
// =============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              mem_read_c,
  input  logic              mem_write_c,
  input  logic              indirect_c,
  input  logic              indirect_write,
  input  logic [1:0]        byte_en_c,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_enable,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              mem_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, ptr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        be_q;
  logic              ind_q, wr_q, indw_q;
  logic              req, timeout, stall_c, sel_ptr, cap_ptr, cap_rd;

  assign req = valid_in & (mem_read_c | mem_write_c | indirect_c);

  always_comb begin
    state_nx         = state;
    stall_c          = 1'b0;
    done             = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b11;
    sel_ptr          = 1'b0;
    cap_ptr          = 1'b0;
    cap_rd           = 1'b0;
    case (state)
      IDLE: begin
        stall_c = req;
        if (req) state_nx = ACC1;
      end
      ACC1: begin
        stall_c = 1'b1;
        if (ind_q) begin
          dmem_read = 1'b1;
        end else begin
          dmem_write       = wr_q;
          dmem_read        = ~wr_q;
          dmem_byte_enable = be_q;
        end
        if (dmem_resp) begin
          cap_ptr  = ind_q;
          cap_rd   = ~ind_q & ~wr_q;
          state_nx = ind_q ? ACC2 : DONE;
        end else if (timeout) begin
          state_nx = DONE;
        end
      end
      ACC2: begin
        stall_c    = 1'b1;
        sel_ptr    = 1'b1;
        dmem_write = indw_q;
        dmem_read  = ~indw_q;
        if (dmem_resp) begin
          cap_rd   = ~indw_q;
          state_nx = DONE;
        end else if (timeout) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Upstream must never see a freeze while the block is held in reset.
  assign stall        = stall_c & rst_n;
  assign dmem_address = (sel_ptr ? ptr_q : addr_q) & ~ADDR_W'(1);
  assign dmem_wdata   = wdata_q;
  assign rdata_out    = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 2'b11;
      ind_q   <= 1'b0;
      wr_q    <= 1'b0;
      indw_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        be_q    <= byte_en_c;
        ind_q   <= indirect_c;
        wr_q    <= mem_write_c;
        indw_q  <= indirect_write;
      end
      if (cap_ptr) ptr_q   <= ADDR_W'(dmem_rdata);
      if (cap_rd)  rdata_q <= dmem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  assign timeout   = ~dmem_resp & (state == ACC1 || state == ACC2) &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign mem_error = err_q & (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout;
      if ((state_nx == ACC1 || state_nx == ACC2) && state_nx != state)
        wait_cnt <= '0;
      else if (~dmem_resp && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl.
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, mem_read_c, mem_write_c, indirect_c, indirect_write;
  logic [1:0]  byte_en_c;
  logic [15:0] addr_in, wdata_in, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write, stall, done, mem_error;
  logic [15:0] dmem_address, dmem_wdata, rdata_out;
  logic [1:0]  dmem_byte_enable;

  int vectors      = 0;
  int miscompares  = 0;
  int stall_cycles = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read_c(mem_read_c),
    .mem_write_c(mem_write_c), .indirect_c(indirect_c), .indirect_write(indirect_write),
    .byte_en_c(byte_en_c), .addr_in(addr_in), .wdata_in(wdata_in),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .stall(stall), .done(done),
    .rdata_out(rdata_out), .mem_error(mem_error)
  );

  typedef struct {
    logic        rd, wr, ind, indw;
    logic [1:0]  be;
    logic [15:0] addr, wd;
    int          w1;
    logic [15:0] r1;
    int          w2;
    logic [15:0] r2;
    logic [15:0] ea1;
    logic        ewr1;
    logic [1:0]  ebe1;
    logic [15:0] ea2;
    logic        ewr2;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT in an access state; serves one cache access.
  task automatic access(input string nm, input logic ewr, input logic [15:0] ea,
                        input logic [1:0] ebe, input logic [15:0] ewd,
                        input int waits, input logic [15:0] rd);
    for (int c = 0; c <= waits; c++) begin
      dmem_resp  = (c == waits);
      dmem_rdata = (c == waits) ? rd : 16'h0;
      #1;
      stall_cycles += int'(stall);
      check({nm, " req"},
            {stall, dmem_read, dmem_write, dmem_byte_enable, dmem_address, (ewr ? dmem_wdata : 16'h0)},
            {1'b1, ~ewr, ewr, ebe, ea, (ewr ? ewd : 16'h0)});
      step();
    end
    dmem_resp  = 1'b0;
    dmem_rdata = 16'h0;
  endtask

  task automatic run_vec(input int i);
    vec_t v = tbl[i];
    valid_in = 1'b1; mem_read_c = v.rd; mem_write_c = v.wr; indirect_c = v.ind;
    indirect_write = v.indw; byte_en_c = v.be; addr_in = v.addr; wdata_in = v.wd;
    #1;
    stall_cycles = int'(stall);
    check($sformatf("v%0d idle", i), {stall, dmem_read, dmem_write, done}, 4'b1000);
    step();
    // Scramble inputs: the access must run from registered values.
    valid_in = 1'b0; mem_read_c = 1'b0; mem_write_c = 1'b1; indirect_c = 1'b0;
    indirect_write = ~v.indw; byte_en_c = 2'b00; addr_in = 16'hDEAD; wdata_in = 16'hBAD0;
    access($sformatf("v%0d acc1", i), v.ewr1, v.ea1, v.ebe1, v.wd, v.w1, v.r1);
    if (v.ind)
      access($sformatf("v%0d acc2", i), v.ewr2, v.ea2, 2'b11, v.wd, v.w2, v.r2);
    #1;
    check($sformatf("v%0d done", i),
          {done, stall, dmem_read, dmem_write, mem_error, rdata_out}, {5'b10000, v.erd});
    check($sformatf("v%0d stall cycles", i), stall_cycles,
          1 + v.w1 + 1 + (v.ind ? v.w2 + 1 : 0));
    mem_write_c = 1'b0; indirect_write = 1'b0;
    step();
  endtask

  initial begin
    //           rd wr ind indw be     addr      wd        w1 r1        w2 r2        ea1       ewr1 ebe1   ea2       ewr2 erd
    tbl[0] = '{1, 0, 0, 0, 2'b11, 16'h3004, 16'h0000, 2, 16'hBEEF, 0, 16'h0000, 16'h3004, 0, 2'b11, 16'h0000, 0, 16'hBEEF};
    tbl[1] = '{0, 1, 0, 0, 2'b10, 16'h2001, 16'h5A00, 0, 16'h0000, 0, 16'h0000, 16'h2000, 1, 2'b10, 16'h0000, 0, 16'hBEEF};
    tbl[2] = '{1, 0, 1, 0, 2'b11, 16'h1000, 16'h0000, 0, 16'h4003, 0, 16'h1234, 16'h1000, 0, 2'b11, 16'h4002, 0, 16'h1234};
    tbl[3] = '{0, 1, 1, 1, 2'b11, 16'h1000, 16'h00FF, 0, 16'h5000, 1, 16'h0000, 16'h1000, 0, 2'b11, 16'h5000, 1, 16'h1234};
    tbl[4] = '{1, 1, 0, 0, 2'b01, 16'h0042, 16'h0077, 1, 16'h0000, 0, 16'h0000, 16'h0042, 1, 2'b01, 16'h0000, 0, 16'h1234};
    tbl[5] = '{1, 0, 0, 0, 2'b01, 16'h7FFF, 16'h0000, 0, 16'h00AB, 0, 16'h0000, 16'h7FFE, 0, 2'b01, 16'h0000, 0, 16'h00AB};
    tbl[6] = '{1, 0, 1, 0, 2'b01, 16'h1001, 16'h0000, 1, 16'hFFFF, 2, 16'hCAFE, 16'h1000, 0, 2'b11, 16'hFFFE, 0, 16'hCAFE};

    rst_n = 1'b0; valid_in = 1'b1; mem_read_c = 1'b1; mem_write_c = 1'b0;
    indirect_c = 1'b0; indirect_write = 1'b0; byte_en_c = 2'b11;
    addr_in = 16'h1111; wdata_in = 16'h2222; dmem_resp = 1'b0; dmem_rdata = 16'h0;
    step();
    #1;
    check("reset gates stall", stall, 1'b0);
    check("reset outputs",
          {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, done, rdata_out, mem_error},
          {2'b00, 16'h0, 16'h0, 2'b11, 1'b0, 16'h0, 1'b0});
    valid_in = 1'b0; mem_read_c = 1'b0;
    step();
    rst_n = 1'b1;

    // Idle for 10 cycles, with a stray cache response that must be ignored.
    for (int i = 0; i < 10; i++) begin
      dmem_resp  = (i == 4);
      dmem_rdata = (i == 4) ? 16'hFFFF : 16'h0;
      #1;
      check($sformatf("idle %0d", i), {stall, dmem_read, dmem_write, done, rdata_out}, 20'h0);
      step();
    end
    dmem_resp = 1'b0; dmem_rdata = 16'h0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset while the second LDI access is outstanding.
    valid_in = 1'b1; indirect_c = 1'b1; mem_read_c = 1'b1; addr_in = 16'h1000; byte_en_c = 2'b11;
    step();
    valid_in = 1'b0; indirect_c = 1'b0; mem_read_c = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 16'h4003;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    #1;
    check("acc2 pending", {dmem_read, stall, dmem_address}, {2'b11, 16'h4002});
    rst_n = 1'b0;
    #1;
    check("acc2 reset gates stall", stall, 1'b0);
    step();
    #1;
    check("after mid-access reset",
          {dmem_read, dmem_write, stall, done, rdata_out, dmem_address}, 36'h0);
    rst_n = 1'b1;
    step();
    run_vec(0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n = 0;
      valid_in = 1'b1; mem_read_c = 1'b1; addr_in = 16'h0100;
      step();
      valid_in = 1'b0; mem_read_c = 1'b0;
      for (int k = 0; k < 400; k++) begin
        #1;
        if (!dmem_read) break;
        n++;
        step();
      end
      check("timeout cycles", n, 255);
      check("timeout done", {done, mem_error, dmem_read, rdata_out}, {3'b110, 16'hBEEF});
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer for the pipelined LC-3b datapath.
- Consumes the memory fields of the control word produced at decode (mem_read, mem_write, indirect_enable, mem_byte_enable), plus the address and store data latched in the EX/MEM register.
- Drives the data-cache handshake and performs the two-access sequence for LDI/STI.
- Asserts stall to freeze upstream pipeline registers until the access completes.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 255, watchdog limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  MEM stage holds a real instruction (not is_nop/flushed).
- mem_read_c  in  1  control word mem_read.
- mem_write_c  in  1  control word mem_write.
- indirect_c  in  1  control word indirect_enable.
- indirect_write  in  1  second indirect access is a write (STI); 0 means LDI.
- byte_en_c  in  2  control word mem_byte_enable.
- addr_in  in  ADDR_W  effective address (MAR value).
- wdata_in  in  DATA_W  store data (MDR value, already byte-filtered).
- dmem_resp  in  1  cache completion pulse.
- dmem_rdata  in  DATA_W  cache read data, valid with dmem_resp.
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_address  out  ADDR_W  cache address.
- dmem_wdata  out  DATA_W  cache write data.
- dmem_byte_enable  out  2  cache byte lanes.
- stall  out  1  freeze IF/ID/EX and EX/MEM registers.
- done  out  1  one-cycle pulse; access complete.
- rdata_out  out  DATA_W  loaded word; held until next load completes.
- mem_error  out  1  watchdog abort pulse (see Optional Feature).

Behaviour:
- req = valid_in & (mem_read_c | mem_write_c | indirect_c).
- States: IDLE, ACC1, ACC2, DONE.
- Reset (rst_n low at a clk edge) forces state IDLE, regardless of current state, including mid-access.
  - After reset: dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=2'b11, done=0, rdata_out=0, mem_error=0.
  - stall is forced 0 while rst_n is low.
- IDLE:
  - stall = req (combinational, same cycle).
  - On req: register address, data, byte_en and type; go to ACC1.
  - No req: stay in IDLE, all requests 0.
- ACC1: first access, driven from registers.
  - indirect: read at addr, byte_en 2'b11.
  - else if mem_write_c: write with byte_en_c (write wins if read and write are both set).
  - else: read with byte_en_c.
  - stall=1. Request is held stable until dmem_resp.
  - On dmem_resp:
    - indirect: latch dmem_rdata as pointer; go to ACC2.
    - direct read: capture rdata_out; go to DONE.
    - direct write: go to DONE.
- ACC2: second access at pointer, byte_en 2'b11.
  - Read if indirect_write=0, else write wdata.
  - stall=1.
  - On dmem_resp: LDI captures rdata_out; go to DONE.
- DONE:
  - done=1, stall=0, dmem_read=dmem_write=0.
  - The pipeline advances this cycle; next state is IDLE unconditionally.
- dmem_address bit 0 is always driven 0; byte lanes are selected by dmem_byte_enable.
- Minimum latency: direct access 3 cycles with 1-cycle cache response (IDLE, ACC1, DONE); indirect access 4 cycles.
- dmem_resp outside ACC1/ACC2 is ignored.
- valid_in or flush changes during ACC1/ACC2 are ignored; an issued access always completes.
- Back-to-back memory instructions: the second one is seen in IDLE the cycle after DONE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on entry to ACC1/ACC2 and increments each cycle without dmem_resp.
  - On reaching TIMEOUT_CYCLES: drop requests, pulse mem_error with done in DONE, leave rdata_out unchanged.
- Undefined: no counter; waits indefinitely; mem_error tied 0.

Test Plan:
- Reset then idle, valid_in=0 for 10 cycles -> stall=0, dmem_read=dmem_write=0, done never asserted.
- LDR: addr_in=0x3004, cache returns 0xBEEF after 2 wait cycles -> dmem_address=0x3004, stall high 4 cycles, done one cycle, rdata_out=0xBEEF.
- STB: addr_in=0x2001, byte_en_c=2'b10, wdata_in=0x5A00 -> dmem_write with address 0x2000, byte_enable 2'b10, wdata 0x5A00; done after resp.
- LDI: addr_in=0x1000 returns pointer 0x4003, then second read returns 0x1234 -> second dmem_address=0x4002, rdata_out=0x1234, 4-cycle minimum latency.
- STI: pointer 0x5000, wdata_in=0x00FF -> read 0x1000, then write 0x00FF to 0x5000 with byte_enable 2'b11.
- Reset asserted in ACC2 with dmem_read high -> next cycle state IDLE, dmem_read=0, stall=0, done=0; with MEM_TIMEOUT_EN and no resp, mem_error pulses after 255 cycles.
